// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int unsigned num_slices(input int unsigned width, input int unsigned slice);
    return width / slice;
  endfunction

  // Slice index register width; a single-slice datapath still needs one bit.
  function automatic int unsigned idx_width(input int unsigned width, input int unsigned slice);
    int unsigned n;
    n = width / slice;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit geometry_ok(input int unsigned width, input int unsigned slice);
    return (slice != 0) && (width != 0) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead slice: sum, carry-out and carry into its MSB.
module cla_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] p;
  logic [SLICE-1:0] g;
  logic [SLICE:0]   c;
  logic             term;
  logic             prod;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is the flattened sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE; i++) begin
      term = g[i];
      prod = p[i];
      for (int unsigned j = 0; j < i; j++) begin
        term = term | (prod & g[i-1-j]);
        prod = prod & p[i-1-j];
      end
      c[i+1] = term | (prod & cin);
    end
  end

  assign sum   = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor resolving one SLICE-bit lookahead slice per clock.
// Optional macro CLA_SEQ_OVERLAP_EN: accept a new operand in the same cycle a result retires.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = num_slices(WIDTH, SLICE);
  localparam int unsigned IW = idx_width(WIDTH, SLICE);

  generate
    if (!geometry_ok(WIDTH, SLICE)) begin : g_bad_geometry
      $error("cla_seq_adder: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             in_ready_r;
  logic             accept;
  logic             last;
  logic [SLICE-1:0] s_sum;
  logic             s_cout;
  logic             s_cmsb;

`ifdef CLA_SEQ_OVERLAP_EN
  assign in_ready = in_ready_r | (out_valid & out_ready);
`else
  assign in_ready = in_ready_r;
`endif

  assign accept = in_valid & in_ready;
  assign last   = (idx == IW'(N - 1));

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a     (a_r[idx*SLICE +: SLICE]),
    .b     (b_r[idx*SLICE +: SLICE]),
    .cin   (carry),
    .sum   (s_sum),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Operand loading is hoisted out of the case so IDLE and the overlapped DONE share it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready_r <= 1'b1;
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      ovf        <= 1'b0;
      idx        <= '0;
      carry      <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
    end else begin
      if (accept) begin
        a_r        <= a;
        b_r        <= sub ? ~b : b;
        carry      <= sub ? 1'b1 : cin;
        idx        <= '0;
        state      <= BUSY;
        in_ready_r <= 1'b0;
      end
      case (state)
        BUSY: begin
          sum[idx*SLICE +: SLICE] <= s_sum;
          carry                   <= s_cout;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= s_cout;
            ovf       <= s_cmsb ^ s_cout;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!accept) begin
              state      <= IDLE;
              in_ready_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16, SLICE=4).
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

`ifdef CLA_SEQ_OVERLAP_EN
  localparam int EXP_INTERVAL = 5;
`else
  localparam int EXP_INTERVAL = 6;
`endif

  cla_seq_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Presents one beat, waits for acceptance and the result; retires it if out_ready is high.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic ci, input logic sb,
                       output logic [15:0] s, output logic co, output logic ov,
                       output int lat, output bit ok);
    int waitc;
    ok = 1'b1; lat = 0; s = '0; co = 1'b0; ov = 1'b0; waitc = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin @(posedge clk); #1; waitc++; end
    if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) begin ok = 1'b0; return; end
    s = sum; co = cout; ov = ovf;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); fails++; end
    tests++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); fails++; end
    tests++; if (sum !== 16'h0000) begin $display("FAIL reset_sum: got %h expected 0000", sum); fails++; end
    tests++; if ({cout, ovf} !== 2'b00) begin $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); fails++; end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] s; logic co, ov; int lat; bit ok;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok) begin $display("FAIL add_timeout: got no result expected result"); fails++; end
    tests++; if (lat !== 4) begin $display("FAIL add_latency: got %0d expected 4", lat); fails++; end
    tests++; if (s !== 16'h5555) begin $display("FAIL add_sum: got %h expected 5555", s); fails++; end
    tests++; if ({co, ov} !== 2'b00) begin $display("FAIL add_flags: got %b expected 00", {co, ov}); fails++; end
    tests++; if ({out_valid, in_ready} !== 2'b01) begin $display("FAIL add_retire: got %b expected 01", {out_valid, in_ready}); fails++; end
    do_op(16'h1234, 16'h4321, 1'b1, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h5556) begin $display("FAIL add_cin_sum: got %h expected 5556", s); fails++; end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] s; logic co, ov; int lat; bit ok;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h0000) begin $display("FAIL wrap_sum: got %h expected 0000", s); fails++; end
    tests++; if ({co, ov} !== 2'b10) begin $display("FAIL wrap_flags: got %b expected 10", {co, ov}); fails++; end
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h8000) begin $display("FAIL ovf_sum: got %h expected 8000", s); fails++; end
    tests++; if ({co, ov} !== 2'b01) begin $display("FAIL ovf_flags: got %b expected 01", {co, ov}); fails++; end
  endtask

  task automatic test_sub();
    logic [15:0] s; logic co, ov; int lat; bit ok;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'hFFFE) begin $display("FAIL sub_borrow_sum: got %h expected fffe", s); fails++; end
    tests++; if ({co, ov} !== 2'b00) begin $display("FAIL sub_borrow_flags: got %b expected 00", {co, ov}); fails++; end
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'hFFFE || co !== 1'b0) begin $display("FAIL sub_cin_ignored: got %h/%b expected fffe/0", s, co); fails++; end
    do_op(16'h0007, 16'h0005, 1'b0, 1'b1, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h0002 || {co, ov} !== 2'b10) begin $display("FAIL sub_noborrow: got %h/%b expected 0002/10", s, {co, ov}); fails++; end
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h7FFF || {co, ov} !== 2'b11) begin $display("FAIL sub_ovf: got %h/%b expected 7fff/11", s, {co, ov}); fails++; end
  endtask

  task automatic test_stall();
    logic [15:0] s; logic co, ov; int lat; bit ok; int bad;
    out_ready = 1'b0;
    do_op(16'h0100, 16'h0200, 1'b0, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h0300) begin $display("FAIL stall_sum: got %h expected 0300", s); fails++; end
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0300 || {cout, ovf} !== 2'b00) bad++;
    end
    tests++; if (bad !== 0) begin $display("FAIL stall_frozen: got %0d bad cycles expected 0", bad); fails++; end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if ({out_valid, in_ready} !== 2'b01) begin $display("FAIL stall_release: got %b expected 01", {out_valid, in_ready}); fails++; end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, ov; int lat; bit ok;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests++; if (sum[3:0] !== 4'hE || out_valid !== 1'b0) begin $display("FAIL mid_partial: got %h/%b expected xxxe/0", sum, out_valid); fails++; end
    rst = 1'b1; #1;
    tests++; if ({out_valid, in_ready} !== 2'b01 || sum !== 16'h0000) begin $display("FAIL mid_reset: got %b/%h expected 01/0000", {out_valid, in_ready}, sum); fails++; end
    rst = 1'b0; #1;
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, lat, ok);
    tests++; if (!ok || s !== 16'h0002 || {co, ov} !== 2'b00 || lat !== 4) begin $display("FAIL mid_after: got %h/%b lat %0d expected 0002/00 lat 4", s, {co, ov}, lat); fails++; end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa [3];
    logic [15:0] ob [3];
    logic        os [3];
    logic [15:0] rs [3];
    logic        rc [3];
    int          t  [3];
    int k, got; logic acc;
    oa[0] = 16'h1234; ob[0] = 16'h4321; os[0] = 1'b0;
    oa[1] = 16'hFFFF; ob[1] = 16'h0001; os[1] = 1'b0;
    oa[2] = 16'h0005; ob[2] = 16'h0007; os[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin rs[i] = '0; rc[i] = 1'b0; t[i] = 0; end
    out_ready = 1'b1; cin = 1'b0; k = 0; got = 0;
    a = oa[0]; b = ob[0]; sub = os[0]; in_valid = 1'b1;
    for (int c = 0; c < 100 && got < 3; c++) begin
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k < 3) begin a = oa[k]; b = ob[k]; sub = os[k]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin rs[got] = sum; rc[got] = cout; t[got] = cyc; got++; end
    end
    in_valid = 1'b0;
    tests++; if (got !== 3) begin $display("FAIL b2b_count: got %0d expected 3", got); fails++; end
    tests++; if (rs[0] !== 16'h5555 || rs[1] !== 16'h0000 || rs[2] !== 16'hFFFE) begin $display("FAIL b2b_sums: got %h %h %h expected 5555 0000 fffe", rs[0], rs[1], rs[2]); fails++; end
    tests++; if ({rc[0], rc[1], rc[2]} !== 3'b010) begin $display("FAIL b2b_couts: got %b expected 010", {rc[0], rc[1], rc[2]}); fails++; end
    tests++; if (t[1] - t[0] !== EXP_INTERVAL || t[2] - t[1] !== EXP_INTERVAL) begin $display("FAIL b2b_interval: got %0d %0d expected %0d", t[1] - t[0], t[2] - t[1], EXP_INTERVAL); fails++; end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Parametrised multi-cycle carry-lookahead adder/subtractor: the next generation of our 4-bit combinational CLA. It is generalised to WIDTH bits and processes one SLICE-bit lookahead slice per clock, carrying the ripple between slices in a register. Operands enter and results leave through valid/ready handshakes, so the block sits between an operand source and a result consumer in the datapath.

## Interface
- WIDTH, 16: operand/result width; must be a positive multiple of SLICE.
- SLICE, 4: bits resolved per cycle by the combinational lookahead slice; N = WIDTH/SLICE cycles per operation.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operand beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  1 = subtract (a - b), 0 = add (a + b + cin).
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB; in subtract mode 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready: latch a, b' = sub ? ~b : b, carry register = sub ? 1 : cin, slice index = 0, go to BUSY.
- BUSY: each cycle the SLICE-bit lookahead slice takes a[idx], b'[idx] and the carry register. It writes its sum bits into sum[idx*SLICE +: SLICE] and its slice carry-out into the carry register, then idx increments. After slice N-1, go to DONE.
- On the last slice, also capture cout = slice carry-out and ovf = carry into bit WIDTH-1 XOR cout.
- DONE: out_valid = 1. sum, cout and ovf stay stable until out_valid & out_ready, then go to IDLE.
- in_ready = 0 in BUSY and DONE, except as described under Configuration.
- Arithmetic is modulo 2^WIDTH. cin is ignored when sub = 1.
- sum holds partial bits while in BUSY; consumers must qualify it with out_valid.

## Timing
- Reset values (asynchronous, any state, including mid-BUSY): state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, idx = 0, carry = 0. The first operand can be accepted on the first edge after rst deasserts.
- Latency: operand accepted at edge k, so out_valid is high from edge k+N.
- N = 1: one BUSY cycle, then DONE.
- Throughput without overlap: one result per N+2 cycles, given IDLE -> BUSY (N cycles) -> DONE (at least 1 cycle) -> IDLE.
- out_ready low in DONE: stall indefinitely; outputs stay frozen.
- in_valid asserted while in_ready = 0: ignored. The source must hold the beat until it is accepted.

## Configuration
- CLA_SEQ_OVERLAP_EN defined: in DONE, in_ready = out_ready. If out_valid & out_ready & in_valid occur in the same cycle, the result is retired and the new operand is latched on that edge, going directly DONE -> BUSY. Throughput becomes one result per N+1 cycles.
- CLA_SEQ_OVERLAP_EN undefined: in_ready is high only in IDLE, and DONE always returns to IDLE first.
- Latency and all other behaviour are identical in both builds.

## Structure
- Package cla_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - a localparam function computing N and the index width as $clog2(N) (minimum 1);
  - an elaboration check that WIDTH % SLICE == 0.
- Sub-module cla_slice: purely combinational SLICE-bit lookahead. It forms P = a^b and G = a&b, computes lookahead carries, and outputs the sum, the carry-out and the carry into its MSB (used for ovf).

## Test plan
- Reset, then add a=0x1234, b=0x4321, cin=0 -> out_valid at accept+4 edges, sum=0x5555, cout=0, ovf=0.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Check that cin is ignored.
- Hold out_ready=0 for 10 cycles in DONE -> outputs frozen, in_ready=0, a new in_valid is not accepted. Release -> IDLE next edge.
- Assert rst during the 2nd BUSY cycle -> out_valid=0, sum=0, in_ready=1 immediately. The next add 0x0001+0x0001 yields 0x0002.
- With CLA_SEQ_OVERLAP_EN: back-to-back beats with out_ready=1 -> results every 5 cycles. Without the macro -> every 6 cycles. Result values match in both builds.
